// File: rtl/vga_timing_gen.sv
// VGA raster timing from a master clock plus pixel-rate enable: sync, active, x/y, frame_start.
// Optional vblank interrupt (irq_n / irq_ack) is built only when VBLANK_IRQ_EN is defined.
module vga_timing_gen #(
    parameter int PCLK_DIV  = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             clr_n,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start
`ifdef VBLANK_IRQ_EN
    ,
    output logic             irq_n,
    input  logic             irq_ack
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);
    localparam logic             SYNC_OFF = ~SYNC_ON;

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] x_nxt;
    logic [CNT_W-1:0] y_nxt;
    logic             x_wrap;

    // Inclusive window test; inclusive upper bound avoids wrap when a window ends at 2**CNT_W.
    function automatic logic in_win(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign pix_en = (div == DIV_LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            div <= '0;
        else if (pix_en)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    always_comb begin
        x_wrap = (x == X_LAST);
        x_nxt  = x_wrap ? '0 : x + CNT_W'(1);
        y_nxt  = y;
        if (x_wrap)
            y_nxt = (y == Y_LAST) ? '0 : y + CNT_W'(1);
    end

    // Sync/active are derived from the next counts so they change on the same edge as x/y.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (x_nxt == '0) && (y_nxt == '0);
            if (pix_en) begin
                x      <= x_nxt;
                y      <= y_nxt;
                hsync  <= in_win(x_nxt, HS_LO, HS_HI) ? SYNC_ON : SYNC_OFF;
                vsync  <= in_win(y_nxt, VS_LO, VS_HI) ? SYNC_ON : SYNC_OFF;
                active <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
            end
        end
    end

`ifdef VBLANK_IRQ_EN
    logic irq_set;

    assign irq_set = pix_en && (x_nxt == '0) && (y_nxt == Y_VIS);

    // A set on the same edge as an acknowledge takes priority.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            irq_n <= 1'b1;
        else if (irq_set)
            irq_n <= 1'b0;
        else if (irq_ack)
            irq_n <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 16x10 raster (8x6 visible), divide-by-2 and divide-by-1.
// IRQ steps are compiled in when VBLANK_IRQ_EN is defined.
module tb_vga_timing_gen;

    logic       clk;
    logic       clr_n;
    logic       a_pe, a_hs, a_vs, a_act, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pe, b_hs, b_vs, b_act, b_fs;
    logic [9:0] b_x, b_y;
`ifdef VBLANK_IRQ_EN
    logic       a_irq_n, b_irq_n, irq_ack;
`endif

    int ntotal = 0;
    int npass  = 0;
    int n, cyc, act, vsl, hsl, lo, hi;

    vga_timing_gen #(
        .PCLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CNT_W(10)
    ) u_a (
        .clk(clk), .clr_n(clr_n), .pix_en(a_pe), .hsync(a_hs), .vsync(a_vs),
        .active(a_act), .x(a_x), .y(a_y), .frame_start(a_fs)
`ifdef VBLANK_IRQ_EN
        , .irq_n(a_irq_n), .irq_ack(irq_ack)
`endif
    );

    vga_timing_gen #(
        .PCLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CNT_W(10)
    ) u_b (
        .clk(clk), .clr_n(clr_n), .pix_en(b_pe), .hsync(b_hs), .vsync(b_vs),
        .active(b_act), .x(b_x), .y(b_y), .frame_start(b_fs)
`ifdef VBLANK_IRQ_EN
        , .irq_n(b_irq_n), .irq_ack(1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        clr_n = 1'b0;
`ifdef VBLANK_IRQ_EN
        irq_ack = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_pe",  a_pe, 0);
        chk("rst_x",   a_x, 15);
        chk("rst_y",   a_y, 9);
        chk("rst_act", a_act, 0);
        chk("rst_fs",  a_fs, 0);
        chk("rst_hs",  a_hs, 1);
        chk("rst_vs",  a_vs, 1);
        chk("rst_b_pe", b_pe, 1);
`ifdef VBLANK_IRQ_EN
        chk("rst_irq", a_irq_n, 1);
`endif

        // release: first edge only advances the divider for u_a
        clr_n = 1'b1;
        @(negedge clk);
        chk("e1_pe", a_pe, 1);
        chk("e1_x",  a_x, 15);
        chk("e1_fs", a_fs, 0);
        chk("e1_b_fs", b_fs, 1);
        chk("e1_b_x",  b_x, 0);
        @(negedge clk);
        chk("e2_fs",  a_fs, 1);
        chk("e2_x",   a_x, 0);
        chk("e2_y",   a_y, 0);
        chk("e2_act", a_act, 1);
        chk("e2_pe",  a_pe, 0);
        chk("e2_hs",  a_hs, 1);
        chk("e2_b_fs", b_fs, 0);

        // one visible line of u_a
        hsl = 0; act = 0; lo = 1023; hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (a_pe && !a_hs) begin
                hsl++;
                if (a_x < lo) lo = a_x;
                if (a_x > hi) hi = a_x;
            end
            if (a_pe && a_act) act++;
            @(negedge clk);
        end
        chk("line_hs_cnt", hsl, 3);
        chk("line_hs_lo",  lo, 10);
        chk("line_hs_hi",  hi, 12);
        chk("line_act",    act, 8);
        chk("line_x",      a_x, 0);
        chk("line_y",      a_y, 1);
        chk("line_fs",     a_fs, 0);

        // two frames of u_a
        n = 0;
        while (!a_fs && n < 1000) begin @(negedge clk); n++; end
        chk("fs_found", (n < 1000), 1);
        for (int f = 0; f < 2; f++) begin
            cyc = 0; act = 0; vsl = 0; lo = 1023; hi = 0;
            do begin
                if (a_pe && a_act) act++;
                if (a_pe && !a_vs) begin
                    vsl++;
                    if (a_y < lo) lo = a_y;
                    if (a_y > hi) hi = a_y;
                end
                @(negedge clk);
                cyc++;
            end while (!a_fs && cyc < 1000);
            chk("frm_period", cyc, 320);
            chk("frm_act",    act, 48);
            chk("frm_vs_cnt", vsl, 32);
            chk("frm_vs_lo",  lo, 7);
            chk("frm_vs_hi",  hi, 8);
        end

        // divide-by-1 instance
        n = 0;
        while (!b_fs && n < 400) begin @(negedge clk); n++; end
        chk("b_fs_found", (n < 400), 1);
        cyc = 0; vsl = 0;
        do begin
            if (!b_pe) vsl++;
            @(negedge clk);
            cyc++;
        end while (!b_fs && cyc < 400);
        chk("b_frm_period", cyc, 160);
        chk("b_pe_low_cnt", vsl, 0);
        n = 0;
        while (b_x != 0 && n < 100) begin @(negedge clk); n++; end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (b_x != 0 && cyc < 100);
        chk("b_line_period", cyc, 16);

`ifdef VBLANK_IRQ_EN
        // clear any pending request from earlier frames
        n = 0;
        while (!a_fs && n < 1000) begin @(negedge clk); n++; end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_clear", a_irq_n, 1);
        n = 0;
        while (a_irq_n && n < 1000) begin @(negedge clk); n++; end
        chk("irq_fell", (n < 1000), 1);
        chk("irq_x",  a_x, 0);
        chk("irq_y",  a_y, 6);
        chk("irq_pe", a_pe, 0);
        repeat (5) @(negedge clk);
        chk("irq_hold", a_irq_n, 0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack", a_irq_n, 1);
        n = 0;
        while (!(a_x == 15 && a_y == 5 && a_pe) && n < 1000) begin @(negedge clk); n++; end
        chk("irq_pre_set", (n < 1000), 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_set_wins", a_irq_n, 0);
        chk("irq_set_y",    a_y, 6);
        repeat (3) @(negedge clk);
        chk("irq_set_hold", a_irq_n, 0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack2", a_irq_n, 1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_ack_idle", a_irq_n, 1);
`endif

        // asynchronous reset mid-frame
        n = 0;
        while (!(a_x == 5 && a_y == 3) && n < 1000) begin @(negedge clk); n++; end
        chk("mid_reach", (n < 1000), 1);
        chk("mid_act",   a_act, 1);
        #2 clr_n = 1'b0;
        #1;
        chk("async_x",   a_x, 15);
        chk("async_y",   a_y, 9);
        chk("async_act", a_act, 0);
        chk("async_hs",  a_hs, 1);
        chk("async_vs",  a_vs, 1);
        chk("async_fs",  a_fs, 0);
        chk("async_pe",  a_pe, 0);
        chk("async_b_x", b_x, 15);
        chk("async_b_y", b_y, 9);
        chk("async_b_hs", b_hs, 1);
        chk("async_b_vs", b_vs, 1);
        chk("async_b_act", b_act, 0);
`ifdef VBLANK_IRQ_EN
        chk("async_irq",   a_irq_n, 1);
        chk("async_b_irq", b_irq_n, 1);
`endif
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        chk("rel_pe", a_pe, 1);
        chk("rel_x",  a_x, 15);
        @(negedge clk);
        chk("rel_fs",  a_fs, 1);
        chk("rel_x0",  a_x, 0);
        chk("rel_y0",  a_y, 0);
        chk("rel_act", a_act, 1);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
